spram_responder: RTL and testbench



---
 rtl/spram_responder.sv | 124 ++++++++++++
 tb/tb_spram_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spram_responder.sv
// ---------------------------------------------------------------------------
// spram_responder
//
// Responder for the single-port RAM bus in front of an SB_SPRAM256KA-style
// macro (one-cycle registered read). Adds a valid/ready request handshake
// and a read-response valid strobe. After reset an optional clear engine
// writes CLEAR_VALUE to every word before any client request is accepted.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   req_valid  client request present
//   req_ready  request accepted this cycle (equal to init_done)
//   req_addr   request word address
//   req_wen    1 = write, 0 = read
//   req_wdata  write data
//   rsp_valid  read data valid this cycle (one cycle after read accept)
//   rsp_rdata  read data; holds the last returned word while rsp_valid=0
//   init_done  clear pass complete
//   mem_addr   to SPRAM ADDRESS
//   mem_wdata  to SPRAM DATAIN
//   mem_wen    to SPRAM WREN
//   mem_rdata  from SPRAM DATAOUT
// ---------------------------------------------------------------------------
module spram_responder #(
    parameter int                ADDR_W         = 14,
    parameter int                DATA_W         = 16,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Reset landing point depends on whether the clear pass is enabled.
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    localparam logic   RESET_DONE  = (CLEAR_ON_RESET == 0);

    state_t            state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              init_done_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] hold_reg;

    logic              accept;
    logic              cnt_last;

    // The counter never wraps: on its all-ones value the FSM leaves CLEAR
    // and the counter is frozen, so there is no second clear pass.
    assign cnt_last  = &cnt_reg;

    assign req_ready = init_done_reg;
    assign accept    = req_valid & req_ready;

    // Bus mux: the clear engine owns the macro in CLEAR, otherwise the
    // client request passes straight through with no extra latency.
    always_comb begin
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        mem_wen   = accept & req_wen;
        if (state_reg == CLEAR) begin
            mem_addr  = cnt_reg;
            mem_wdata = CLEAR_VALUE;
            mem_wen   = 1'b1;
        end
    end

    // Read data is taken straight from the macro on the response cycle and
    // captured so it stays visible once rsp_valid drops.
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_valid_reg ? mem_rdata : hold_reg;
    assign init_done = init_done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RESET_STATE;
            cnt_reg       <= '0;
            init_done_reg <= RESET_DONE;
            rsp_valid_reg <= 1'b0;
            hold_reg      <= '0;
        end else begin
            rsp_valid_reg <= accept & ~req_wen;
            if (rsp_valid_reg) begin
                hold_reg <= mem_rdata;
            end
            case (state_reg)
                CLEAR: begin
                    if (cnt_last) begin
                        state_reg     <= READY;
                        init_done_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                READY: begin
                    state_reg <= READY;
                end
                default: begin
                    state_reg <= RESET_STATE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spram_responder.sv
// ---------------------------------------------------------------------------
// tb_spram_responder
//
// Directed bench for spram_responder with ADDR_W=4, CLEAR_VALUE=0xA5A5 and a
// behavioural SPRAM (registered read, one-cycle latency). Inputs are driven
// 1 time unit after the rising edge, outputs checked 1 unit later.
// ---------------------------------------------------------------------------
module tb_spram_responder;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] CLR = 16'hA5A5;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              init_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spram_responder #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .CLEAR_ON_RESET(1),
        .CLEAR_VALUE   (CLR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_wen  (req_wen),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wen  (mem_wen),
        .mem_rdata(mem_rdata)
    );

    // Behavioural single-port RAM, read-before-write on the same edge.
    logic [DATA_W-1:0] ram [2**ADDR_W];
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid = v;
        req_wen   = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        if (v) $display("t=%0t req %s addr=%0d wdata=%h", $time, w ? "WR" : "RD", a, d);
    endtask

    task automatic idle();
        set_req(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a write request held high the whole time.
        reset = 1'b1;
        set_req(1'b1, 1'b1, 4'hF, 16'hDEAD);
        step();
        step();
        check_value("rst_rsp_valid", rsp_valid, 0);
        check_value("rst_init_done", init_done, 0);
        check_value("rst_req_ready", req_ready, 0);
        check_value("rst_rsp_rdata", rsp_rdata, 0);
        check_value("rst_mem_addr", mem_addr, 0);

        reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            check_value("clr_wen", mem_wen, 1);
            check_value("clr_addr", mem_addr, i);
            check_value("clr_wdata", mem_wdata, CLR);
            check_value("clr_req_ready", req_ready, 0);
            check_value("clr_init_done", init_done, 0);
            step();
        end
        // First READY cycle: held write is accepted.
        check_value("rdy_init_done", init_done, 1);
        check_value("rdy_req_ready", req_ready, 1);
        check_value("held_wen", mem_wen, 1);
        check_value("held_addr", mem_addr, 4'hF);
        check_value("held_wdata", mem_wdata, 16'hDEAD);
        $display("t=%0t req WR addr=15 wdata=dead (held through clear)", $time);
        step();
        check_value("wr_no_rsp", rsp_valid, 0);
        set_req(1'b1, 1'b0, 4'hF, '0);
        check_value("rd_wen_low", mem_wen, 0);
        step();
        check_value("rd15_valid", rsp_valid, 1);
        check_value("rd15_data", rsp_rdata, 16'hDEAD);
        set_req(1'b1, 1'b0, 4'd7, '0);
        step();
        check_value("rd7_valid", rsp_valid, 1);
        check_value("rd7_data", rsp_rdata, CLR);

        // Read-after-write on consecutive cycles.
        set_req(1'b1, 1'b1, 4'd5, 16'hBEEF);
        step();
        check_value("wr5_no_rsp", rsp_valid, 0);
        set_req(1'b1, 1'b0, 4'd5, '0);
        step();
        check_value("raw5_valid", rsp_valid, 1);
        check_value("raw5_data", rsp_rdata, 16'hBEEF);

        // Three writes then back-to-back reads 3,1,2.
        set_req(1'b1, 1'b1, 4'd1, 16'h1111); step();
        set_req(1'b1, 1'b1, 4'd2, 16'h2222); step();
        set_req(1'b1, 1'b1, 4'd3, 16'h3333); step();
        check_value("wr3_no_rsp", rsp_valid, 0);
        set_req(1'b1, 1'b0, 4'd3, '0); step();
        check_value("b2b0_valid", rsp_valid, 1);
        check_value("b2b0_data", rsp_rdata, 16'h3333);
        set_req(1'b1, 1'b0, 4'd1, '0); step();
        check_value("b2b1_valid", rsp_valid, 1);
        check_value("b2b1_data", rsp_rdata, 16'h1111);
        set_req(1'b1, 1'b0, 4'd2, '0); step();
        check_value("b2b2_valid", rsp_valid, 1);
        check_value("b2b2_data", rsp_rdata, 16'h2222);
        idle();
        for (int i = 0; i < 10; i++) begin
            step();
            check_value("hold_valid", rsp_valid, 0);
            check_value("hold_data", rsp_rdata, 16'h2222);
        end

        // Reset pulse mid-clear at counter 9.
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 9; i++) step();
        check_value("mid_addr9", mem_addr, 9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_value("restart_addr", mem_addr, 0);
        check_value("restart_done", init_done, 0);
        for (int i = 0; i < 15; i++) step();
        check_value("restart_done15", init_done, 0);
        check_value("restart_addr15", mem_addr, 15);
        step();
        check_value("restart_done16", init_done, 1);
        check_value("restart_ready16", req_ready, 1);

        // Reset in the same cycle as a read acceptance.
        set_req(1'b1, 1'b0, 4'd5, '0);
        reset = 1'b1;
        #1;
        check_value("rstrd_ready", req_ready, 1);
        step();
        reset = 1'b0;
        idle();
        check_value("rstrd_valid", rsp_valid, 0);
        check_value("rstrd_done", init_done, 0);
        check_value("rstrd_data", rsp_rdata, 0);
        for (int n = 0; n < 40 && !init_done; n++) step();
        check_value("clear_finish", init_done, 1);
        set_req(1'b1, 1'b0, 4'd5, '0);
        step();
        idle();
        check_value("rd5_clr_valid", rsp_valid, 1);
        check_value("rd5_clr_data", rsp_rdata, CLR);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
